// File: rtl/addsub_iter.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per cycle, carry rippled through a register.
// Optional signed saturation when ADDSUB_ITER_SAT_EN is defined.
module addsub_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

  logic [CHUNK:0]   c_sum;
  logic [WIDTH-1:0] acc_nx, res;
  logic             c_msb, ovf_nx;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    c_sum  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy_q};
    // New chunk enters at the top; after NCH chunks the accumulator holds the full result.
    acc_nx = WIDTH'({c_sum[CHUNK-1:0], acc_q} >> CHUNK);
    // On the last chunk, bit CHUNK-1 is the word MSB; recover the carry into it.
    c_msb  = c_sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
    ovf_nx = c_msb ^ c_sum[CHUNK];
    res    = acc_nx;
`ifdef ADDSUB_ITER_SAT_EN
    if (ovf_nx)
      res = a_q[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          cy_d    = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        acc_d = acc_nx;
        cy_d  = c_sum[CHUNK];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = res;
          cout_d  = c_sum[CHUNK];
          ovf_d   = ovf_nx;
          zero_d  = (res == '0);
          neg_d   = res[WIDTH-1];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
endmodule

// File: tb/tb_addsub_iter.sv
// Bench for addsub_iter: 32/8 directed table plus corner sequences, 16/16 and 12/4 against a reference model.
module tb_addsub_iter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] ta, tbv;
  logic        tsub;
  logic [2:0]  iv, ordy, ir, ov, co, of, ze, ng;
  logic [31:0] s32;
  logic [15:0] s16;
  logic [11:0] s12;

  addsub_iter #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(ta), .b(tbv), .sub(tsub),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s32), .cout(co[0]), .ovf(of[0]), .zero(ze[0]), .neg(ng[0]));
  addsub_iter #(.WIDTH(16), .CHUNK(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(ta[15:0]), .b(tbv[15:0]), .sub(tsub),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s16), .cout(co[1]), .ovf(of[1]), .zero(ze[1]), .neg(ng[1]));
  addsub_iter #(.WIDTH(12), .CHUNK(4)) u12 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(ta[11:0]), .b(tbv[11:0]), .sub(tsub),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s12), .cout(co[2]), .ovf(of[2]), .zero(ze[2]), .neg(ng[2]));

  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] a, b;
    logic        s;
    logic [31:0] es;
    logic [3:0]  ef;  // {cout, ovf, zero, neg}
  } vec_t;
  vec_t tv[10];

  function automatic logic [31:0] rsum(int d);
    case (d)
      0:       return s32;
      1:       return {16'd0, s16};
      default: return {20'd0, s12};
    endcase
  endfunction

  function automatic logic [3:0] rflg(int d);
    return {co[d], of[d], ze[d], ng[d]};
  endfunction

  // Independent reference: full-width add, signed overflow from operand/result signs.
  function automatic logic [35:0] model(int w, logic [31:0] x, logic [31:0] y, logic s);
    logic [32:0] full;
    logic [31:0] m, xa, yb, r;
    logic        c, o;
    int          k;
    k    = w - 1;
    m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    xa   = x & m;
    yb   = (s ? ~y : y) & m;
    full = {1'b0, xa} + {1'b0, yb} + {32'd0, s};
    r    = full[31:0] & m;
    c    = full[w];
    o    = (xa[k] == yb[k]) && (r[k] != xa[k]);
`ifdef ADDSUB_ITER_SAT_EN
    if (o) r = xa[k] ? (32'd1 << k) : ((32'd1 << k) - 32'd1);
`endif
    return {c, o, (r == 32'd0), r[k], r};
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // Start an op on DUT d and wait (bounded) for out_valid; lat counts edges after the accept edge.
  task automatic op(int d, logic [31:0] x, logic [31:0] y, logic s, output int lat);
    int w;
    w = 0;
    while (!ir[d] && w < 100) begin @(posedge clk); #1; w++; end
    chk("in_ready_before_op", {31'd0, ir[d]}, 32'd1);
    ta = x; tbv = y; tsub = s; iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    ta = $urandom; tbv = $urandom; tsub = ~s;  // must have no effect after accept
    lat = 0;
    while (!ov[d] && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic pop(int d);
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [35:0] e;
    logic        stable;
    logic [31:0] x, y;
    logic        s;

    rst = 1'b1; iv = '0; ordy = '0; ta = '0; tbv = '0; tsub = 1'b0;
    tv[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 4'b0000};
    tv[1] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 4'b0001};
    tv[2] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 4'b1010};
`ifdef ADDSUB_ITER_SAT_EN
    tv[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0100};
    tv[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b1101};
    tv[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'b1101};
`else
    tv[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0101};
    tv[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b1100};
    tv[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b1110};
`endif
    tv[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010};
    tv[6] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 4'b0000};
    tv[7] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 4'b0001};
    tv[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b1010};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, ir[0]}, 32'd1);
    chk("reset_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("reset_sum", s32, 32'd0);
    chk("reset_flags", {28'd0, rflg(0)}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      op(0, tv[i].a, tv[i].b, tv[i].s, lat);
      chk($sformatf("vec%0d_latency", i), lat, 32'd4);
      chk($sformatf("vec%0d_sum", i), s32, tv[i].es);
      chk($sformatf("vec%0d_flags", i), {28'd0, rflg(0)}, {28'd0, tv[i].ef});
      pop(0);
    end

    // Backpressure: result held, in_valid ignored while in DONE.
    op(0, 32'h11, 32'h22, 1'b0, lat);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin ta = 32'h5555_5555; tbv = 32'h1; tsub = 1'b1; iv[0] = 1'b1; end
      @(posedge clk); #1;
      iv[0] = 1'b0;
      if (s32 !== 32'h33 || rflg(0) !== 4'b0000 || ir[0] !== 1'b0 || ov[0] !== 1'b1) stable = 1'b0;
    end
    chk("bp_stable", {31'd0, stable}, 32'd1);
    pop(0);
    chk("bp_in_ready_after", {31'd0, ir[0]}, 32'd1);
    chk("bp_out_valid_after", {31'd0, ov[0]}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_no_spurious_op", {31'd0, ov[0]}, 32'd0);
    chk("bp_sum_held", s32, 32'h33);

    // Reset two chunks into RUN.
    ta = 32'hFFFF_FFFF; tbv = 32'h1; tsub = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrun_rst_sum", s32, 32'd0);
    chk("midrun_rst_in_ready", {31'd0, ir[0]}, 32'd1);
    chk("midrun_rst_out_valid", {31'd0, ov[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    op(0, 32'd1, 32'd1, 1'b0, lat);
    chk("post_rst_latency", lat, 32'd4);
    chk("post_rst_sum", s32, 32'd2);
    chk("post_rst_flags", {28'd0, rflg(0)}, 32'd0);
    pop(0);

    // Single-chunk and three-chunk instances against the model.
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 20; i++) begin
        x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1));
        if (i == 0) begin x = 32'h7FFF_FFFF; y = 32'h1; s = 1'b0; end
        if (i == 1) begin x = 32'h0; y = 32'h0; s = 1'b1; end
        e = model((d == 1) ? 16 : 12, x, y, s);
        op(d, x, y, s, lat);
        chk($sformatf("w%0d_latency", d), lat, (d == 1) ? 32'd1 : 32'd3);
        chk($sformatf("w%0d_sum_%0d", d, i), rsum(d), e[31:0]);
        chk($sformatf("w%0d_flags_%0d", d, i), {28'd0, rflg(d)}, {28'd0, e[35:32]});
        pop(d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/addsub_iter.md
# addsub_iter

Parametrised, multi-cycle two's-complement adder/subtractor. It processes a WIDTH-bit operation CHUNK bits per cycle, rippling the carry between chunks through a register. It replaces the flat 32-bit ripple-carry add/sub in the ALU datapath where area matters more than latency. Operands enter and results leave through valid/ready handshakes, and every result carries carry, overflow, zero and negative flags.

## Interface
- WIDTH, default 32: operand and result width. Must be a multiple of CHUNK, and at least 2.
- CHUNK, default 8: bits added per cycle. NCH = WIDTH/CHUNK, the number of cycles per operation.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and mode are valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A−B (computed as A + ~B + 1)
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result
- cout  output  1  carry out of the MSB (for sub, 1 = no borrow)
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  output  1  sum == 0
- neg  output  1  sum[WIDTH-1]

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch a into the A shift register and b XOR {WIDTH{sub}} into the B shift register.
  - Set the carry register to sub and the chunk counter to 0, then go to RUN.
- RUN:
  - Each cycle, add the low CHUNK bits of A, the low CHUNK bits of B and the carry register.
  - Shift the CHUNK-bit result into the top of the accumulator, shift A and B right by CHUNK, and update the carry register.
  - On the last chunk (counter == NCH−1):
    - Capture the carry into the MSB to form ovf.
    - Load sum, cout, ovf, zero and neg from the completed result.
    - Go to DONE.
- DONE:
  - out_valid = 1.
  - On out_ready, go to IDLE.
  - sum and the flags stay unchanged while waiting.
- in_ready = (state == IDLE), driven combinationally from the state register.
- A new operation is never accepted in DONE, even in the same cycle as the output handshake.
- Inputs a, b and sub are sampled only at the accept edge; later changes have no effect.
- The result registers update only on the RUN→DONE transition. Outside DONE, sum and the flags hold the last result.
- Arithmetic is modulo 2^WIDTH. cout follows the unsigned meaning and ovf the signed meaning, for both add and sub.
- CHUNK == WIDTH is legal: NCH = 1, so RUN lasts one cycle.

## Timing
- Reset, applied asynchronously at any time including mid-RUN or in DONE:
  - State returns to IDLE and the operation in flight is discarded.
  - out_valid = 0 and in_ready = 1.
  - sum, cout, ovf, zero and neg = 0.
  - Counter, carry and all shift registers are cleared.
- Latency:
  - The accept edge is edge 0.
  - out_valid rises after edge NCH (edge 4 for the default parameters).
- Throughput: one operation every NCH+2 cycles when out_ready is held high (accept, NCH RUN cycles, one DONE cycle).
- out_valid and the result stay stable until the edge where out_ready = 1. out_valid deasserts on the following cycle.
- in_ready rises in the cycle after the output handshake.

## Configuration
- ADDSUB_ITER_SAT_EN defined: signed saturation.
  - When ovf = 1, sum is forced to 2^(WIDTH−1)−1 if the true result sign is positive (operand A non-negative), or to −2^(WIDTH−1) otherwise.
  - ovf stays 1, cout is unchanged, and zero/neg are computed from the saturated sum.
- ADDSUB_ITER_SAT_EN undefined: sum is the wrapped modulo result. No saturation logic is built.

## Test plan
- Default parameters. Add 0x0000_0005 + 0x0000_0003, sub = 0 → after 4 cycles: sum = 0x0000_0008, cout = 0, ovf = 0, zero = 0, neg = 0.
- Sub 0x0000_0003 − 0x0000_0005 → sum = 0xFFFF_FFFE, cout = 0, neg = 1, ovf = 0. Sub 5 − 5 → sum = 0, zero = 1, cout = 1.
- Add 0x7FFF_FFFF + 0x0000_0001 → ovf = 1 and cout = 0. sum = 0x8000_0000 without the macro, 0x7FFF_FFFF with ADDSUB_ITER_SAT_EN. Add 0xFFFF_FFFF + 0x0000_0001 → sum = 0, cout = 1, ovf = 0.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid → sum and flags stable, in_ready = 0, and an in_valid pulse in that window is ignored. Raising out_ready → in_ready = 1 on the next cycle.
- Reset mid-RUN (after 2 chunks) → outputs 0 and in_ready = 1 immediately. A fresh operation 1 + 1 then completes correctly with sum = 2.
- WIDTH = 16, CHUNK = 16 and WIDTH = 12, CHUNK = 4, random add/sub operands checked against a reference model → latency 1 and 3 respectively, and all results and flags match.
